muldiv_sched: RTL and testbench

Sequencing controller for the EX-stage multiply/divide resource and the HI/LO register pair. It accepts div/divu/mult/multu/mthi/mtlo/mfhi/mflo from EX and runs an iterative 32-step shift-add multiplier or restoring divider. While an operation runs it raises `stallreq` toward the stall controller. It commits results to HI/LO and serves mfhi/mflo reads combinationally.

---
 rtl/muldiv_sched_if.sv | 37 +++
 rtl/muldiv_sched.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// Bundles the EX-stage request lines and the stall/HI/LO result lines of the
// multiply/divide sequencer. The master side is the EX stage; the slave side
// is muldiv_sched.
interface muldiv_sched_if #(
  parameter int XLEN = 32
);
  logic            op_div;
  logic            op_divu;
  logic            op_mult;
  logic            op_multu;
  logic            op_mthi;
  logic            op_mtlo;
  logic            op_mfhi;
  logic            op_mflo;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            cancel;
  logic            stallreq;
  logic            busy;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;
  logic [XLEN-1:0] hilo_rdata;

  modport master (
    output op_div, op_divu, op_mult, op_multu,
    output op_mthi, op_mtlo, op_mfhi, op_mflo,
    output src_a, src_b, cancel,
    input  stallreq, busy, hi_o, lo_o, hilo_rdata
  );

  modport slave (
    input  op_div, op_divu, op_mult, op_multu,
    input  op_mthi, op_mtlo, op_mfhi, op_mflo,
    input  src_a, src_b, cancel,
    output stallreq, busy, hi_o, lo_o, hilo_rdata
  );
endinterface

// File: rtl/muldiv_sched.sv
// Iterative multiply/divide sequencer with the architectural HI/LO pair.
// One shift-add (mult) or restoring-subtract (div) step per cycle, XLEN steps,
// then a single DONE cycle in which the pipeline releases the instruction.
module muldiv_sched #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_sched_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  // mult: {partial product high half, remaining multiplier bits}
  // div:  {partial remainder, dividend bits shifting into quotient}
  logic [2*XLEN-1:0]   work;
  logic [XLEN-1:0]     opnd;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]     a_raw;     // unmodified src_a, returned as HI on divide by zero
  logic                neg_lo;    // negate product / quotient at the end
  logic                neg_hi;    // negate remainder at the end
  logic                div_zero;
  logic [XLEN-1:0]     hi_q;
  logic [XLEN-1:0]     lo_q;

  logic                start_req;
  logic                sel_div;
  logic                sel_signed;
  logic                last_step;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [2*XLEN-1:0]   mul_final;
  logic [XLEN:0]       div_shift;
  logic [XLEN+1:0]     div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     quot_final;
  logic [XLEN-1:0]     rem_final;

  assign start_req = bus.op_div | bus.op_divu | bus.op_mult | bus.op_multu;
  assign last_step = (cnt == CW'(XLEN - 1));

  // Decode the winning request (div > divu > mult > multu) and one step of each datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_div    = bus.op_div | bus.op_divu;
    sel_signed = bus.op_div | (~bus.op_divu & bus.op_mult);
    a_mag      = (sel_signed && bus.src_a[XLEN-1]) ? -bus.src_a : bus.src_a;
    b_mag      = (sel_signed && bus.src_b[XLEN-1]) ? -bus.src_b : bus.src_b;

    mul_sum    = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
    mul_next   = {mul_sum, work[XLEN-1:1]};
    mul_final  = neg_lo ? -mul_next : mul_next;

    div_shift  = work[2*XLEN-1:XLEN-1];
    div_diff   = {1'b0, div_shift} - {2'b00, opnd};
    if (!div_diff[XLEN+1]) begin
      div_next = {div_diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], work[XLEN-2:0], 1'b0};
    end

    quot_final = neg_lo ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    rem_final  = neg_hi ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    if (div_zero) begin
      quot_final = '1;
      rem_final  = a_raw;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always falls back to IDLE so a held request cannot restart.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!bus.cancel) begin
          if (sel_div) begin
            state_nxt = S_DIV;
          end else if (bus.op_mult | bus.op_multu) begin
            state_nxt = S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (bus.cancel) begin
          state_nxt = S_IDLE;
        end else if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration, HI/LO commit and mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.cancel) begin
            if (start_req) begin
              cnt      <= '0;
              a_raw    <= bus.src_a;
              neg_lo   <= sel_signed & (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
              neg_hi   <= sel_signed & sel_div & bus.src_a[XLEN-1];
              div_zero <= (bus.src_b == '0);
              if (sel_div) begin
                work <= {{XLEN{1'b0}}, a_mag};
                opnd <= b_mag;
              end else begin
                work <= {{XLEN{1'b0}}, b_mag};
                opnd <= a_mag;
              end
            end else if (bus.op_mthi) begin
              hi_q <= bus.src_a;
            end else if (bus.op_mtlo) begin
              lo_q <= bus.src_a;
            end
          end
        end
        S_MUL: begin
          if (bus.cancel) begin
            cnt <= '0;
          end else begin
            work <= mul_next;
            cnt  <= cnt + CW'(1);
            if (last_step) begin
              hi_q <= mul_final[2*XLEN-1:XLEN];
              lo_q <= mul_final[XLEN-1:0];
            end
          end
        end
        S_DIV: begin
          if (bus.cancel) begin
            cnt <= '0;
          end else begin
            work <= div_next;
            cnt  <= cnt + CW'(1);
            if (last_step) begin
              hi_q <= rem_final;
              lo_q <= quot_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is combinational so the request cycle itself holds the pipeline.
  always_comb begin
    bus.stallreq = ~bus.cancel &
                   (((state == S_IDLE) & start_req) | (state == S_MUL) | (state == S_DIV));
    bus.busy     = (state == S_MUL) | (state == S_DIV);
    bus.hi_o     = hi_q;
    bus.lo_o     = lo_q;
    if (bus.op_mfhi) begin
      bus.hilo_rdata = hi_q;
    end else if (bus.op_mflo) begin
      bus.hilo_rdata = lo_q;
    end else begin
      bus.hilo_rdata = '0;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: a table of multiply/divide vectors with
// hand-computed HI/LO, each checked for exact stall/busy timing, plus short
// sequences for HI/LO moves, cancel and reset in the middle of an operation.
module tb_muldiv_sched;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sched_if #(.XLEN(XLEN)) bus();
  muldiv_sched #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ops = {div, divu, mult, multu}
  typedef struct {
    string       name;
    logic [3:0]  ops;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    bus.op_div   = 1'b0;
    bus.op_divu  = 1'b0;
    bus.op_mult  = 1'b0;
    bus.op_multu = 1'b0;
    bus.op_mthi  = 1'b0;
    bus.op_mtlo  = 1'b0;
    bus.op_mfhi  = 1'b0;
    bus.op_mflo  = 1'b0;
    bus.cancel   = 1'b0;
    bus.src_a    = '0;
    bus.src_b    = '0;
  endtask

  // Present the op in cycle 0 and hold it (as a stalled EX stage would) through DONE.
  task automatic run_vec(input vec_t v);
    int stalls;
    int busys;
    stalls = 0;
    busys  = 0;
    {bus.op_div, bus.op_divu, bus.op_mult, bus.op_multu} = v.ops;
    bus.src_a = v.a;
    bus.src_b = v.b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy) busys++;
      if (!bus.stallreq) break;
      stalls++;
      next_cycle();
    end
    check({v.name, " stall cycles"}, stalls, 33);
    check({v.name, " busy cycles"}, busys, 32);
    check({v.name, " HI in DONE"}, bus.hi_o, v.hi);
    check({v.name, " LO in DONE"}, bus.lo_o, v.lo);
    next_cycle();
    clear_ops();
    @(negedge clk);
    check({v.name, " busy after DONE"}, 32'(bus.busy), 32'd0);
    check({v.name, " stall after DONE"}, 32'(bus.stallreq), 32'd0);
    next_cycle();
  endtask

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{"multu max",     4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"multu small",   4'b0001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780});
    vecs.push_back('{"mult min*min",  4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"mult 0*-1",     4'b0010, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{"div -7/2",      4'b1000, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div 7/-2",      4'b1000, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{"div min/-1",    4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"divu 100/0",    4'b0100, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
    vecs.push_back('{"div -7/0",      4'b1000, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{"divu max/16",   4'b0100, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
    vecs.push_back('{"prio div>mult", 4'b1010, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E});
    vecs.push_back('{"prio divu>mu",  4'b0101, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF});
    vecs.push_back('{"prio mult>mu",  4'b0011, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{"mult -3*7",     4'b0010, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});

    // Reset state.
    clear_ops();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    bus.op_mfhi = 1'b1;
    @(negedge clk);
    check("reset stallreq", 32'(bus.stallreq), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset HI", bus.hi_o, 32'd0);
    check("reset LO", bus.lo_o, 32'd0);
    check("reset rdata", bus.hilo_rdata, 32'd0);
    next_cycle();
    rst = 1'b0;
    clear_ops();
    next_cycle();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reads after mult -3*7 (last vector): combinational, no stall.
    bus.op_mflo = 1'b1;
    @(negedge clk);
    check("mflo rdata", bus.hilo_rdata, 32'hFFFF_FFEB);
    check("mflo stall", 32'(bus.stallreq), 32'd0);
    next_cycle();
    clear_ops();
    bus.op_mfhi = 1'b1;
    @(negedge clk);
    check("mfhi rdata", bus.hilo_rdata, 32'hFFFF_FFFF);
    next_cycle();
    clear_ops();
    @(negedge clk);
    check("idle rdata", bus.hilo_rdata, 32'd0);
    next_cycle();

    // mthi then mfhi in the following cycle.
    bus.op_mthi = 1'b1;
    bus.src_a   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi stall", 32'(bus.stallreq), 32'd0);
    next_cycle();
    clear_ops();
    bus.op_mfhi = 1'b1;
    @(negedge clk);
    check("mfhi after mthi", bus.hilo_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // mthi wins over mtlo when both are asserted.
    clear_ops();
    bus.op_mthi = 1'b1;
    bus.op_mtlo = 1'b1;
    bus.src_a   = 32'h0000_0055;
    next_cycle();
    clear_ops();
    @(negedge clk);
    check("mthi+mtlo HI", bus.hi_o, 32'h0000_0055);
    check("mthi+mtlo LO", bus.lo_o, 32'hFFFF_FFEB);
    next_cycle();

    // Preload HI=LO=0x11, then show cancel suppresses an IDLE move and an IDLE start.
    bus.op_mthi = 1'b1;
    bus.src_a   = 32'h0000_0011;
    next_cycle();
    clear_ops();
    bus.op_mtlo = 1'b1;
    bus.src_a   = 32'h0000_0011;
    next_cycle();
    clear_ops();
    bus.op_mthi = 1'b1;
    bus.cancel  = 1'b1;
    bus.src_a   = 32'h0000_0099;
    next_cycle();
    clear_ops();
    @(negedge clk);
    check("cancelled mthi HI", bus.hi_o, 32'h0000_0011);
    next_cycle();
    bus.op_mult = 1'b1;
    bus.cancel  = 1'b1;
    bus.src_a   = 32'd3;
    bus.src_b   = 32'd5;
    @(negedge clk);
    check("cancelled start stall", 32'(bus.stallreq), 32'd0);
    next_cycle();
    clear_ops();
    @(negedge clk);
    check("cancelled start busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // div 50/7 cancelled in cycle 10.
    bus.op_div = 1'b1;
    bus.src_a  = 32'd50;
    bus.src_b  = 32'd7;
    repeat (10) next_cycle();
    bus.cancel = 1'b1;
    @(negedge clk);
    check("cancel cycle stall", 32'(bus.stallreq), 32'd0);
    check("cancel cycle busy", 32'(bus.busy), 32'd1);
    next_cycle();
    clear_ops();
    @(negedge clk);
    check("after cancel busy", 32'(bus.busy), 32'd0);
    check("after cancel stall", 32'(bus.stallreq), 32'd0);
    check("after cancel HI", bus.hi_o, 32'h0000_0011);
    check("after cancel LO", bus.lo_o, 32'h0000_0011);
    next_cycle();

    // A full op after cancel must run its whole count from zero.
    run_vec('{"divu 50/7 post-cancel", 4'b0100, 32'd50, 32'd7, 32'd1, 32'd7});

    // Reset in the middle of a divide.
    bus.op_div = 1'b1;
    bus.src_a  = 32'd50;
    bus.src_b  = 32'd7;
    repeat (5) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    clear_ops();
    @(negedge clk);
    check("mid-div rst HI", bus.hi_o, 32'd0);
    check("mid-div rst LO", bus.lo_o, 32'd0);
    check("mid-div rst stall", 32'(bus.stallreq), 32'd0);
    check("mid-div rst busy", 32'(bus.busy), 32'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
